// File: rtl/serial_divisibility_scheduler.sv
// Two-requester round-robin front end for a bit-serial mod-3 / mod-5 remainder engine.
// One operand is accepted at a time and the result is held until the consumer takes it.
module serial_divisibility_scheduler #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req0_valid,
  output logic             req0_ready,
  input  logic [WIDTH-1:0] req0_data,
  input  logic             req0_div5,
  input  logic             req1_valid,
  output logic             req1_ready,
  input  logic [WIDTH-1:0] req1_data,
  input  logic             req1_div5,
  output logic             res_valid,
  input  logic             res_ready,
  output logic             res_id,
  output logic             res_div,
  output logic [2:0]       res_rem
);

  localparam int CW = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

  state_t           state, state_next;
  logic [WIDTH-1:0] op_q;
  logic             div5_q;
  logic             id_q;
  logic             prefer1_q;
  logic [2:0]       rem_q;
  logic [CW-1:0]    cnt_q;
  logic             grant0, grant1, accept;
  logic [3:0]       twice, modulus, rem_sum;
  logic [2:0]       rem_next;

  // Readies are gated by reset so nothing can be handed over before release.
  always_comb begin
    grant0 = 1'b0;
    grant1 = 1'b0;
    if (rst && state == IDLE) begin
      if (req1_valid && (!req0_valid || prefer1_q)) grant1 = 1'b1;
      else if (req0_valid)                          grant0 = 1'b1;
    end
  end

  assign accept     = grant0 | grant1;
  assign req0_ready = grant0;
  assign req1_ready = grant1;

  // 2*rem + bit never exceeds 2*N-1, so one conditional subtract keeps rem in range.
  always_comb begin
    twice    = {rem_q, op_q[WIDTH-1]};
    modulus  = div5_q ? 4'd5 : 4'd3;
    rem_sum  = (twice >= modulus) ? (twice - modulus) : twice;
    rem_next = rem_sum[2:0];
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (accept) state_next = SHIFT;
      SHIFT:   if (cnt_q == CW'(1)) state_next = DONE;
      DONE:    if (res_ready) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= IDLE;
      op_q      <= '0;
      div5_q    <= 1'b0;
      id_q      <= 1'b0;
      prefer1_q <= 1'b0;
      rem_q     <= 3'd0;
      cnt_q     <= '0;
    end else begin
      state <= state_next;
      case (state)
        IDLE: begin
          if (accept) begin
            op_q      <= grant1 ? req1_data : req0_data;
            div5_q    <= grant1 ? req1_div5 : req0_div5;
            id_q      <= grant1;
            prefer1_q <= grant0;
            rem_q     <= 3'd0;
            cnt_q     <= CW'(WIDTH);
          end
        end
        SHIFT: begin
          op_q  <= {op_q[WIDTH-2:0], 1'b0};
          rem_q <= rem_next;
          cnt_q <= cnt_q - CW'(1);
        end
        default: ;
      endcase
    end
  end

  assign res_valid = (state == DONE);
  assign res_id    = id_q;
  assign res_rem   = rem_q;
  assign res_div   = (state == DONE) && (rem_q == 3'd0);

endmodule

// File: doc/serial_divisibility_scheduler.md
SERIAL_DIVISIBILITY_SCHEDULER -- requirements
Module: serial_divisibility_scheduler

Interface
REQ-001 SHALL have parameter WIDTH, default 8, meaning operand width in bits (legal range 2..16).
REQ-002 SHALL have port clk  input  1  the single clock; all state updates on its rising edge.
REQ-003 SHALL have port rst  input  1  asynchronous, active-low reset.
REQ-004 SHALL have port req0_valid  input  1  requester 0 holds an operand.
REQ-005 SHALL have port req0_ready  output  1  requester 0 operand accepted this cycle.
REQ-006 SHALL have port req0_data  input  WIDTH  requester 0 operand, unsigned.
REQ-007 SHALL have port req0_div5  input  1  requester 0 divisor select: 1 = 5, 0 = 3.
REQ-008 SHALL have ports req1_valid, req1_ready, req1_data and req1_div5 with the same directions, widths and meaning for requester 1.
REQ-009 SHALL have port res_valid  output  1  result available.
REQ-010 SHALL have port res_ready  input  1  consumer takes the result.
REQ-011 SHALL have port res_id  output  1  index of the requester that owns the result.
REQ-012 SHALL have port res_div  output  1  1 when the operand is divisible by the selected divisor.
REQ-013 SHALL have port res_rem  output  3  operand modulo the selected divisor.

Function
REQ-014 SHALL implement a controller FSM with states IDLE, SHIFT and DONE.
REQ-015 In IDLE with at least one valid request, it SHALL grant exactly one requester, assert only that requester's ready for one cycle (combinational from state and valids), latch its data, div5 and id, clear the remainder to 0, load the bit counter with WIDTH, and go to SHIFT.
REQ-016 Arbitration SHALL be round-robin: a lone valid request wins; when both are valid, the requester not granted last wins; after reset requester 0 has priority.
REQ-017 req0_ready and req1_ready SHALL be 0 in SHIFT and DONE, and never 1 simultaneously.
REQ-018 In SHIFT, each cycle SHALL consume one latched operand bit, MSB first: rem_next = (2*rem + bit) mod N, with N = 5 if div5 else 3, and rem always kept in 0..N-1.
REQ-019 After WIDTH SHIFT cycles the FSM SHALL go to DONE; the result SHALL appear with res_valid = 1 exactly WIDTH+1 cycles after the accept cycle.
REQ-020 In DONE: res_valid = 1; res_rem = final remainder; res_div = (res_rem == 0); res_id = granted requester.
REQ-021 In DONE, res_id, res_div and res_rem SHALL stay stable until res_valid && res_ready.
REQ-022 On res_valid && res_ready the FSM SHALL return to IDLE; no new request is accepted in that same cycle (minimum issue interval WIDTH+2 cycles).
REQ-023 Requester inputs SHALL be ignored outside the accept cycle; later changes to the data SHALL not affect the result.
REQ-024 Operand 0 SHALL give res_rem = 0 and res_div = 1 for either divisor.
REQ-025 res_valid SHALL be 0 in IDLE and SHIFT; res_id, res_div and res_rem are don't-care while res_valid = 0.

Reset
REQ-026 While rst = 0 the block SHALL asynchronously enter IDLE with res_valid = 0, both readies = 0, res_id = 0, res_div = 0, res_rem = 0, remainder = 0, counter = 0, round-robin pointer favouring requester 0.
REQ-027 Reset asserted mid-SHIFT or in DONE SHALL abort the operation and discard the result; no res_valid SHALL follow for it after reset release.
REQ-028 The first accept SHALL occur no earlier than the first rising edge after rst returns to 1.

Verification
REQ-029 WIDTH=8, req0 data 15, div5=1, res_ready=1: req0_ready pulses once; 9 cycles later res_valid=1, res_id=0, res_rem=0, res_div=1.
REQ-030 req1 data 14, div5=0: res_id=1, res_rem=2, res_div=0; data 255 with div5=0 and with div5=1: res_rem=0 and res_div=1 in both cases.
REQ-031 Both requesters valid continuously from reset release: grants alternate 0,1,0,1 and each result carries the matching res_id and remainder.
REQ-032 res_ready held 0 for 5 cycles in DONE: res_valid and result outputs stay constant, both readies stay 0; then res_ready=1: IDLE next cycle.
REQ-033 rst pulled low in the 4th SHIFT cycle of req0 data 7: outputs reach their reset values immediately, and no res_valid occurs after release until a new request is accepted.
REQ-034 Data 0 with div5=1 and req0 data changed during SHIFT: result is res_rem=0, res_div=1, unaffected by the change.
